// File: rtl/uart_rx_ctrl_if.sv
// Host/RX-core signal bundle for uart_rx_ctrl: configuration handshake,
// RX-core status, receive FIFO read port and error counters.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  cfg_wr;
    logic [4:0]            cfg_prescale;
    logic                  cfg_par_en;
    logic                  cfg_busy;
    logic                  cfg_err;
    logic [4:0]            prescale;
    logic                  PAR_EN;
    logic                  rx_enable;
    logic                  rx_busy;
    logic                  rx_frame_done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_par_err;
    logic                  rx_stp_err;
    logic                  rd_en;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;
    logic [CNT_WIDTH-1:0]  ovr_cnt;
    logic                  clr_cnt;

    modport slave (
        input  cfg_wr, cfg_prescale, cfg_par_en,
        input  rx_busy, rx_frame_done, rx_data, rx_par_err, rx_stp_err,
        input  rd_en, clr_cnt,
        output cfg_busy, cfg_err, prescale, PAR_EN, rx_enable,
        output rd_valid, rd_data, par_err_cnt, stp_err_cnt, ovr_cnt
    );

    modport master (
        output cfg_wr, cfg_prescale, cfg_par_en,
        output rx_busy, rx_frame_done, rx_data, rx_par_err, rx_stp_err,
        output rd_en, clr_cnt,
        input  cfg_busy, cfg_err, prescale, PAR_EN, rx_enable,
        input  rd_valid, rd_data, par_err_cnt, stp_err_cnt, ovr_cnt
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: frame-safe reconfiguration FSM, FWFT receive FIFO
// and saturating parity/stop/overrun error counters.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN_WAIT,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    localparam int         PTR_W          = $clog2(FIFO_DEPTH);
    localparam int         SET_W          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [4:0] RESET_PRESCALE = 5'd8;
    localparam logic [4:0] MIN_PRESCALE   = 5'd4;

    state_t            r_state, w_state_nxt;
    logic [SET_W-1:0]  r_settle_cnt, w_settle_cnt_nxt;
    logic [4:0]        r_pend_prescale, r_prescale;
    logic              r_pend_par_en, r_par_en;
    logic              r_rx_enable, r_cfg_busy, r_cfg_err;
    logic              w_cfg_ok, w_cfg_accept, w_load_cfg, w_cfg_reject;

    // ---------------- configuration FSM ----------------
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_cfg_accept     = 1'b0;
        w_load_cfg       = 1'b0;
        w_cfg_ok         = (bus.cfg_prescale >= MIN_PRESCALE);
        case (r_state)
            ST_RUN: begin
                if (bus.cfg_wr && w_cfg_ok) begin
                    w_cfg_accept = 1'b1;
                    w_state_nxt  = ST_DRAIN_WAIT;
                end
            end
            ST_DRAIN_WAIT: begin
                if (!bus.rx_busy) w_state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                w_load_cfg       = 1'b1;
                w_settle_cnt_nxt = SET_W'(SETTLE_CYCLES - 1);
                w_state_nxt      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle_cnt == '0) w_state_nxt = ST_RUN;
                else                    w_settle_cnt_nxt = r_settle_cnt - SET_W'(1);
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Anything other than an accepted request from RUN is a rejection.
    assign w_cfg_reject = bus.cfg_wr && !w_cfg_accept;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_settle_cnt    <= '0;
            r_pend_prescale <= RESET_PRESCALE;
            r_pend_par_en   <= 1'b0;
            r_prescale      <= RESET_PRESCALE;
            r_par_en        <= 1'b0;
            r_rx_enable     <= 1'b1;
            r_cfg_busy      <= 1'b0;
            r_cfg_err       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            if (w_cfg_accept) begin
                r_pend_prescale <= bus.cfg_prescale;
                r_pend_par_en   <= bus.cfg_par_en;
            end
            if (w_load_cfg) begin
                r_prescale <= r_pend_prescale;
                r_par_en   <= r_pend_par_en;
            end
            r_rx_enable <= !(w_state_nxt == ST_APPLY || w_state_nxt == ST_SETTLE);
            r_cfg_busy  <= (w_state_nxt != ST_RUN);
            r_cfg_err   <= w_cfg_reject;
        end
    end

    // ---------------- frame intake and FIFO ----------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  w_par_hit, w_stp_hit, w_good;
    logic                  w_empty, w_full, w_pop, w_push, w_ovr;

    assign w_par_hit = bus.rx_frame_done && bus.rx_par_err && r_par_en;
    assign w_stp_hit = bus.rx_frame_done && bus.rx_stp_err;
    assign w_good    = bus.rx_frame_done && !(bus.rx_par_err && r_par_en) && !bus.rx_stp_err;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop     = bus.rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign w_push    = w_good && (!w_full || w_pop);
    assign w_ovr     = w_good && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only observable after
    // it has been written, and resetting it would waste flops.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.rx_data;
    end

    // ---------------- saturating error counters ----------------
    logic [CNT_WIDTH-1:0] r_par_cnt, r_stp_cnt, r_ovr_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            r_par_cnt <= '0;
            r_stp_cnt <= '0;
            r_ovr_cnt <= '0;
        end else begin
            if (w_par_hit && r_par_cnt != '1) r_par_cnt <= r_par_cnt + CNT_WIDTH'(1);
            if (w_stp_hit && r_stp_cnt != '1) r_stp_cnt <= r_stp_cnt + CNT_WIDTH'(1);
            if (w_ovr     && r_ovr_cnt != '1) r_ovr_cnt <= r_ovr_cnt + CNT_WIDTH'(1);
        end
    end

    // ---------------- outputs ----------------
    assign bus.cfg_busy    = r_cfg_busy;
    assign bus.cfg_err     = r_cfg_err;
    assign bus.prescale    = r_prescale;
    assign bus.PAR_EN      = r_par_en;
    assign bus.rx_enable   = r_rx_enable;
    assign bus.rd_valid    = !w_empty;
    assign bus.rd_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.par_err_cnt = r_par_cnt;
    assign bus.stp_err_cnt = r_stp_cnt;
    assign bus.ovr_cnt     = r_ovr_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: config sequencing, FIFO
// ordering/overflow, error counting, saturation and reset during SETTLE.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

    uart_rx_ctrl #(
        .DATA_WIDTH    (8),
        .FIFO_DEPTH    (4),
        .CNT_WIDTH     (8),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge(s).
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] data, input logic par, input logic stp);
        bus.rx_frame_done = 1'b1;
        bus.rx_data       = data;
        bus.rx_par_err    = par;
        bus.rx_stp_err    = stp;
        tick();
        bus.rx_frame_done = 1'b0;
        bus.rx_par_err    = 1'b0;
        bus.rx_stp_err    = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp [4], input int n);
        bus.rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            check(tag, bus.rd_data, exp[i]);
            tick();
        end
        bus.rd_en = 1'b0;
        check({tag, "_empty"}, bus.rd_valid, 0);
    endtask

    initial begin
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];

        bus.cfg_wr = 0; bus.cfg_prescale = 0; bus.cfg_par_en = 0;
        bus.rx_busy = 0; bus.rx_frame_done = 0; bus.rx_data = 0;
        bus.rx_par_err = 0; bus.rx_stp_err = 0; bus.rd_en = 0; bus.clr_cnt = 0;

        // Reset held for two cycles
        tick(2);
        rst = 1'b0;
        check("rst_prescale", bus.prescale, 8);
        check("rst_par_en",   bus.PAR_EN, 0);
        check("rst_rx_en",    bus.rx_enable, 1);
        check("rst_busy",     bus.cfg_busy, 0);
        check("rst_cfg_err",  bus.cfg_err, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data",  bus.rd_data, 0);
        check("rst_cnts",     {bus.par_err_cnt, bus.stp_err_cnt, bus.ovr_cnt}, 0);

        // Parity error ignored while PAR_EN=0
        frame(8'h5A, 1'b1, 1'b0);
        check("nopar_valid", bus.rd_valid, 1);
        check("nopar_data",  bus.rd_data, 8'h5A);
        check("nopar_cnt",   bus.par_err_cnt, 0);
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        check("nopar_pop", bus.rd_valid, 0);

        // Illegal prescale in RUN
        bus.cfg_prescale = 5'd3; bus.cfg_par_en = 1'b1; bus.cfg_wr = 1'b1;
        tick(); bus.cfg_wr = 1'b0;
        check("bad_err",  bus.cfg_err, 1);
        check("bad_busy", bus.cfg_busy, 0);
        tick();
        check("bad_err_pulse", bus.cfg_err, 0);
        check("bad_prescale",  bus.prescale, 8);

        // Config while idle: cfg_wr at t
        bus.cfg_prescale = 5'd16; bus.cfg_par_en = 1'b1; bus.cfg_wr = 1'b1;
        tick(); bus.cfg_wr = 1'b0;                       // t+1
        check("idle_busy_t1",  bus.cfg_busy, 1);
        check("idle_rxen_t1",  bus.rx_enable, 1);
        check("idle_err_t1",   bus.cfg_err, 0);
        tick();                                           // t+2
        check("idle_rxen_t2",  bus.rx_enable, 0);
        check("idle_pre_t2",   bus.prescale, 8);
        tick();                                           // t+3
        check("idle_pre_t3",   bus.prescale, 16);
        check("idle_par_t3",   bus.PAR_EN, 1);
        check("idle_rxen_t3",  bus.rx_enable, 0);
        tick();                                           // t+4
        check("idle_rxen_t4",  bus.rx_enable, 0);
        check("idle_busy_t4",  bus.cfg_busy, 1);
        tick();                                           // t+5
        check("idle_rxen_t5",  bus.rx_enable, 1);
        check("idle_busy_t5",  bus.cfg_busy, 0);

        // PAR_EN=1: frame with both errors is dropped, both counters bump
        frame(8'h33, 1'b1, 1'b1);
        check("both_valid", bus.rd_valid, 0);
        check("both_par",   bus.par_err_cnt, 1);
        check("both_stp",   bus.stp_err_cnt, 1);

        // Config during a frame, rx_busy high for 40 cycles
        bus.rx_busy = 1'b1;
        bus.cfg_prescale = 5'd12; bus.cfg_par_en = 1'b0; bus.cfg_wr = 1'b1;
        tick(); bus.cfg_wr = 1'b0;
        check("busy_cfg_busy", bus.cfg_busy, 1);
        tick(9);
        bus.cfg_prescale = 5'd20; bus.cfg_par_en = 1'b1; bus.cfg_wr = 1'b1;
        tick(); bus.cfg_wr = 1'b0;
        check("busy_second_err", bus.cfg_err, 1);
        tick();
        check("busy_err_pulse", bus.cfg_err, 0);
        tick(28);
        check("busy_wait_pre",  bus.prescale, 16);
        check("busy_wait_rxen", bus.rx_enable, 1);
        check("busy_wait_busy", bus.cfg_busy, 1);
        bus.rx_busy = 1'b0;
        tick();
        check("busy_apply_rxen", bus.rx_enable, 0);
        check("busy_apply_pre",  bus.prescale, 16);
        tick();
        check("busy_new_pre", bus.prescale, 12);
        check("busy_new_par", bus.PAR_EN, 0);
        tick(2);
        check("busy_run_rxen", bus.rx_enable, 1);
        check("busy_run_busy", bus.cfg_busy, 0);

        // FIFO ordering and overflow
        for (int i = 0; i < 5; i++) frame(8'hA1 + 8'(i), 1'b0, 1'b0);
        check("ovr_head",  bus.rd_data, 8'hA1);
        check("ovr_valid", bus.rd_valid, 1);
        check("ovr_cnt",   bus.ovr_cnt, 1);
        exp_a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        pop_check("order", exp_a, 4);

        // Full FIFO: push with simultaneous pop
        for (int i = 0; i < 4; i++) frame(8'hB1 + 8'(i), 1'b0, 1'b0);
        check("full_ovr_pre", bus.ovr_cnt, 1);
        bus.rd_en = 1'b1;
        frame(8'hB5, 1'b0, 1'b0);
        bus.rd_en = 1'b0;
        check("full_ovr_same", bus.ovr_cnt, 1);
        exp_b = '{8'hB2, 8'hB3, 8'hB4, 8'hB5};
        pop_check("fullpop", exp_b, 4);

        // Push to empty with rd_en in the same cycle is not popped
        bus.rd_en = 1'b1;
        frame(8'hC1, 1'b0, 1'b0);
        bus.rd_en = 1'b0;
        check("empty_push_valid", bus.rd_valid, 1);
        check("empty_push_data",  bus.rd_data, 8'hC1);
        bus.rd_en = 1'b1; tick(2); bus.rd_en = 1'b0;
        check("empty_rd_ignored", bus.rd_valid, 0);

        // Stop-error counter saturation
        bus.rx_frame_done = 1'b1; bus.rx_stp_err = 1'b1; bus.rx_data = 8'hEE;
        tick(300);
        bus.rx_frame_done = 1'b0; bus.rx_stp_err = 1'b0;
        check("sat_stp",   bus.stp_err_cnt, 255);
        check("sat_valid", bus.rd_valid, 0);

        // Clear beats a simultaneous error increment
        bus.clr_cnt = 1'b1;
        frame(8'h11, 1'b0, 1'b1);
        bus.clr_cnt = 1'b0;
        check("clr_par", bus.par_err_cnt, 0);
        check("clr_stp", bus.stp_err_cnt, 0);
        check("clr_ovr", bus.ovr_cnt, 0);

        // Reset during SETTLE discards the new config
        bus.cfg_prescale = 5'd24; bus.cfg_par_en = 1'b1; bus.cfg_wr = 1'b1;
        tick(); bus.cfg_wr = 1'b0;
        tick(2);
        check("settle_pre",  bus.prescale, 24);
        check("settle_rxen", bus.rx_enable, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_settle_pre",  bus.prescale, 8);
        check("rst_settle_par",  bus.PAR_EN, 0);
        check("rst_settle_rxen", bus.rx_enable, 1);
        check("rst_settle_busy", bus.cfg_busy, 0);
        tick(3);
        check("rst_settle_stay", {bus.cfg_busy, bus.prescale}, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
